// File: rtl/pipe_mem_responder_if.sv
// Valid/ready request and response bundle between a pipeline cache port
// (master) and the memory-side responder (slave).
interface pipe_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);

  // Request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;

  // Response channel
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_is_wr;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_is_wr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_data, resp_is_wr
  );

endinterface

// File: rtl/pipe_mem_responder.sv
// Memory-side responder: word array accessed at request accept, a fixed
// latency pipe carrying the response, and a response FIFO that absorbs
// consumer backpressure. A credit counter covering pipe plus FIFO keeps the
// FIFO from ever overflowing, so no response is ever dropped.
module pipe_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input logic                clk,
  input logic                reset_n,
  pipe_mem_responder_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam int OCC_W  = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL = RESP_DEPTH;
  localparam logic [OCC_W-1:0] OCC_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_LAST = RESP_DEPTH - 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  // Storage and control state
  logic                r_active;
  logic [OCC_W-1:0]    r_occ;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                r_pipeValid [LATENCY];
  logic [DATA_W-1:0]   r_pipeData  [LATENCY];
  logic                r_pipeWr    [LATENCY];

  logic [DATA_W-1:0]   r_fifoData [RESP_DEPTH];
  logic                r_fifoWr   [RESP_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [OCC_W-1:0]    r_fifoCount;

  // Combinational helpers
  logic                w_reqReady;
  logic                w_accept;
  logic                w_respValid;
  logic                w_pop;
  logic                w_push;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_curWord;
  logic [DATA_W-1:0]   w_mergedWord;
  logic                w_unusedAddrBits;

  // Byte offset bits carry no meaning for a word-organised array
  assign w_unusedAddrBits = ^bus.req_addr[1:0];

  // Handshakes: credit-limited accept, head-of-FIFO pop, pipe tail push
  assign w_reqReady  = r_active && (r_occ < OCC_FULL);
  assign w_accept    = bus.req_valid && w_reqReady;
  assign w_respValid = (r_fifoCount != '0);
  assign w_pop       = w_respValid && bus.resp_ready;
  assign w_push      = r_pipeValid[LATENCY-1];

  assign w_idx     = bus.req_addr[IDX_W+1:2];
  assign w_curWord = r_mem[w_idx];

  // Merge write data into the current word under the byte strobes
  always_comb begin
    w_mergedWord = w_curWord;
    for (int b = 0; b < STRB_W; b++) begin
      if (bus.req_wstrb[b]) begin
        w_mergedWord[8*b +: 8] = bus.req_wdata[8*b +: 8];
      end
    end
  end

  // Hold off accepts until the first clock edge after reset is released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Credit count of requests somewhere between accept and pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Word array: written with the merged word on an accepted WRITE, never reset
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_op) begin
      r_mem[w_idx] <= w_mergedWord;
    end
  end

  // Fixed-latency pipe, loaded at accept and shifted every cycle without stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipeValid[i] <= 1'b0;
        r_pipeData[i]  <= '0;
        r_pipeWr[i]    <= 1'b0;
      end
    end else begin
      r_pipeValid[0] <= w_accept;
      r_pipeData[0]  <= bus.req_op ? w_mergedWord : w_curWord;
      r_pipeWr[0]    <= bus.req_op;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeData[i]  <= r_pipeData[i-1];
        r_pipeWr[i]    <= r_pipeWr[i-1];
      end
    end
  end

  // FIFO payload storage, written at the tail when the pipe delivers an entry
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= r_pipeData[LATENCY-1];
      r_fifoWr[r_wrPtr]   <= r_pipeWr[LATENCY-1];
    end
  end

  // FIFO write pointer, wrapping modulo the FIFO depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
    end else if (w_push) begin
      r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_ONE;
    end
  end

  // FIFO read pointer, advancing on each consumer pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdPtr <= '0;
    end else if (w_pop) begin
      r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTR_ONE;
    end
  end

  // FIFO fill level; a push into an empty FIFO shows up the following cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifoCount <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_fifoCount <= r_fifoCount + OCC_ONE;
        2'b01:   r_fifoCount <= r_fifoCount - OCC_ONE;
        default: r_fifoCount <= r_fifoCount;
      endcase
    end
  end

  // Outputs: head entry, forced to zero whenever nothing is presented
  assign bus.req_ready  = w_reqReady;
  assign bus.resp_valid = w_respValid;
  assign bus.resp_data  = w_respValid ? r_fifoData[r_rdPtr] : '0;
  assign bus.resp_is_wr = w_respValid ? r_fifoWr[r_rdPtr] : 1'b0;

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Scoreboard bench for pipe_mem_responder: a reference word model predicts
// every response at accept time, and a monitor pops and compares in order.
module tb_pipe_mem_responder;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 2;
  localparam int RESP_DEPTH = 4;
  localparam int ADDR_W     = $clog2(DEPTH) + 2;

  typedef struct {
    bit          isWr;
    logic [31:0] data;
    int          acceptCycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pipe_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pipe_mem_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        expQ[$];
  exp_t        monExp;
  logic [31:0] model [int];
  int          checkCount = 0;
  int          passCount = 0;
  int          cycleCount = 0;
  int          stallCount = 0;
  bit          latencyCheck = 1'b0;

  always @(posedge clk) cycleCount++;

  // Monitor: every handshake pops the oldest prediction and compares it
  always @(negedge clk) begin
    if (reset_n && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_resp got data=%h is_wr=%b, expected no response", bus.resp_data, bus.resp_is_wr);
      end else begin
        monExp = expQ.pop_front();
        if (bus.resp_data !== monExp.data || bus.resp_is_wr !== monExp.isWr) begin
          $display("[TB] FAIL resp_payload got data=%h is_wr=%b, expected data=%h is_wr=%b", bus.resp_data, bus.resp_is_wr, monExp.data, monExp.isWr);
        end else begin
          passCount++;
        end
        if (latencyCheck) begin
          checkCount++;
          if (cycleCount - monExp.acceptCycle != LATENCY) begin
            $display("[TB] FAIL resp_latency got %0d cycles, expected %0d", cycleCount - monExp.acceptCycle, LATENCY);
          end else begin
            passCount++;
          end
        end
      end
    end
  end

  // Reference model update and prediction for one accepted request
  function automatic void acceptModel(input bit op, input logic [ADDR_W-1:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wstrb, input int acc);
    int          idx;
    logic [31:0] cur;
    logic [31:0] merged;
    exp_t        e;
    idx = int'(addr[ADDR_W-1:2]);
    cur = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    e.isWr = op;
    e.acceptCycle = acc;
    if (op) begin
      model[idx] = merged;
      e.data = merged;
    end else begin
      e.data = cur;
    end
    expQ.push_back(e);
  endfunction

  // Present one request until accepted (bounded); called and returns at posedge+1
  task automatic issue(input bit op, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    int waited = 0;
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    while (!ok && waited < 64) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
      else begin
        waited++;
        stallCount++;
      end
    end
    if (ok) acceptModel(op, addr, wdata, wstrb, cycleCount + 1);
    else begin
      checkCount++;
      $display("[TB] FAIL issue_timeout got req_ready=%b for 64 cycles, expected 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Let every predicted response come out, then confirm nothing extra follows
  task automatic drain(input string name);
    int n = 0;
    bus.resp_ready = 1'b1;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) $display("[TB] FAIL %s_drain got %0d pending, expected 0", name, expQ.size());
    else passCount++;
    checkCount++;
    if (bus.resp_valid !== 1'b0) $display("[TB] FAIL %s_idle got resp_valid=%b, expected 0", name, bus.resp_valid);
    else passCount++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready got %b, expected 0", bus.req_ready);
    else passCount++;
    checkCount++;
    if (bus.resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %b, expected 0", bus.resp_valid);
    else passCount++;
    checkCount++;
    if (bus.resp_data !== 32'h0) $display("[TB] FAIL reset_resp_data got %h, expected 0", bus.resp_data);
    else passCount++;
    checkCount++;
    if (bus.resp_is_wr !== 1'b0) $display("[TB] FAIL reset_resp_is_wr got %b, expected 0", bus.resp_is_wr);
    else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL release_req_ready got %b, expected 0 before first edge", bus.req_ready);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL first_edge_req_ready got %b, expected 1", bus.req_ready);
    else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    latencyCheck = 1'b1;
    bus.resp_ready = 1'b1;
    issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    drain("basic");
    latencyCheck = 1'b0;
  endtask

  task automatic test_strobes();
    bus.resp_ready = 1'b1;
    issue(1'b1, 12'h020, 32'h11223344, 4'hF);
    issue(1'b1, 12'h020, 32'hAABBCCDD, 4'h5);
    issue(1'b0, 12'h020, 32'h0, 4'h0);
    issue(1'b1, 12'h020, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 12'h020, 32'h0, 4'h0);
    drain("strobes");
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    logic [31:0] heldData;
    logic        heldWr;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, ADDR_W'(12'h040 + 4 * i), 32'hB0000000 + i, 4'hF);
    drain("bp_setup");
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b0;
      bus.req_addr  = ADDR_W'(12'h040 + 4 * acc);
      bus.req_wstrb = 4'h0;
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        acceptModel(1'b0, bus.req_addr, 32'h0, 4'h0, cycleCount + 1);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checkCount++;
    if (acc != RESP_DEPTH) $display("[TB] FAIL bp_accepts got %0d, expected %0d", acc, RESP_DEPTH);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL bp_full_ready got %b, expected 0", bus.req_ready);
    else passCount++;
    heldData = bus.resp_data;
    heldWr   = bus.resp_is_wr;
    @(negedge clk);
    checkCount++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== heldData || bus.resp_is_wr !== heldWr)
      $display("[TB] FAIL bp_hold got valid=%b data=%h, expected valid=1 data=%h", bus.resp_valid, bus.resp_data, heldData);
    else passCount++;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL bp_after_pop_ready got %b, expected 1", bus.req_ready);
    else passCount++;
    @(posedge clk);
    #1;
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int stallBefore;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, ADDR_W'(4 * i), 32'hC0DE0000 + i, 4'hF);
    drain("b2b_setup");
    latencyCheck = 1'b1;
    stallBefore = stallCount;
    for (int i = 0; i < 8; i++) issue(1'b0, ADDR_W'(4 * i), 32'h0, 4'h0);
    checkCount++;
    if (stallCount != stallBefore) $display("[TB] FAIL b2b_stalls got %0d, expected 0", stallCount - stallBefore);
    else passCount++;
    drain("back_to_back");
    latencyCheck = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [ADDR_W-1:0] a;
    bit                op;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, ADDR_W'(4 * i), 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_addr  = 12'h00C;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b1)
      $display("[TB] FAIL simul_handshake got req_ready=%b resp_valid=%b, expected 1 1", bus.req_ready, bus.resp_valid);
    else passCount++;
    if (bus.req_ready === 1'b1) acceptModel(1'b0, 12'h00C, 32'h0, 4'h0, cycleCount + 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL simul_occ_ready got %b, expected 1", bus.req_ready);
    else passCount++;
    @(posedge clk);
    #1;
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    @(negedge clk);
    checkCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL simul_refill_ready got %b, expected 0", bus.req_ready);
    else passCount++;
    @(posedge clk);
    #1;
    drain("simultaneous");
    for (int i = 0; i < 3 * RESP_DEPTH; i++) begin
      bus.resp_ready = (expQ.size() >= RESP_DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      op = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = ADDR_W'(12'h100 + 4 * (i % 4));
      issue(op, a, $urandom, (i < 4) ? 4'hF : 4'($urandom_range(0, 15)));
    end
    drain("wrap");
  endtask

  task automatic test_reset_midflight();
    bit sawValid = 1'b0;
    bus.resp_ready = 1'b1;
    issue(1'b1, 12'h200, 32'hCAFEF00D, 4'hF);
    drain("mid_setup");
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 12'h200, 32'h0, 4'h0);
    checkCount++;
    if (bus.resp_valid !== 1'b1) $display("[TB] FAIL mid_pre_valid got %b, expected 1", bus.resp_valid);
    else passCount++;
    #2;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.req_ready !== 1'b0)
      $display("[TB] FAIL mid_async got valid=%b data=%h ready=%b, expected 0 0 0", bus.resp_valid, bus.resp_data, bus.req_ready);
    else passCount++;
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) sawValid = 1'b1;
    end
    checkCount++;
    if (sawValid) $display("[TB] FAIL mid_stale got resp_valid=1 after reset, expected 0");
    else passCount++;
    @(posedge clk);
    #1;
    issue(1'b0, 12'h200, 32'h0, 4'h0);
    drain("reset_midflight");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_basic();
    test_strobes();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
